// File: rtl/divu_seq_ctrl.sv
// Sequential 32-bit unsigned restoring divider with valid/ready handshake on both sides.
// Optional macro DIVU_SEQ_ZERO_FAST_EN: a zero divisor finishes one cycle after accept.
module divu_seq_ctrl #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_div_by_zero,
    output logic        o_busy
);

    localparam int         CYCLES   = 32 / STEPS_PER_CYCLE;
    localparam logic [5:0] LAST_CNT = 6'(CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_dvd;
    logic [31:0] r_dsr;
    logic [31:0] r_rem;
    logic [5:0]  r_cnt;
    logic        r_zero;
    logic [31:0] r_quo_out;
    logic [31:0] r_rem_out;
    logic        r_dbz_out;
    logic [31:0] w_dvd_next;
    logic [31:0] w_rem_next;
    logic        w_accept;
    logic        w_last;
    logic        w_finish;

    // One restoring step. The shifted remainder is formed in 33 bits so the
    // compare sees the bit shifted out of rem[31]; after a subtract the
    // remainder is below the divisor again, so 32 bits are enough to store it.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] dvd,
                                             input logic [31:0] dsr);
        logic [32:0] v_rem;
        logic [31:0] v_dvd;
        v_rem = {rem, dvd[31]};
        v_dvd = {dvd[30:0], 1'b0};
        if (v_rem >= {1'b0, dsr}) begin
            v_rem    = v_rem - {1'b0, dsr};
            v_dvd[0] = 1'b1;
        end
        return {v_rem[31:0], v_dvd};
    endfunction

    always_comb begin
        w_rem_next = r_rem;
        w_dvd_next = r_dvd;
        for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
            {w_rem_next, w_dvd_next} = div_step(w_rem_next, w_dvd_next, r_dsr);
        end
    end

    assign w_accept = i_valid & (r_state == S_IDLE);
`ifdef DIVU_SEQ_ZERO_FAST_EN
    assign w_last   = r_zero | (r_cnt == LAST_CNT);
`else
    assign w_last   = (r_cnt == LAST_CNT);
`endif
    assign w_finish = (r_state == S_BUSY) & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_next = S_BUSY;
            S_BUSY:  if (w_last)  w_state_next = S_DONE;
            S_DONE:  if (i_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: bits shift in at the LSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvd  <= i_dividend;
            r_dsr  <= i_divisor;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_zero <= (i_divisor == '0);
        end else if (r_state == S_BUSY) begin
            r_dvd  <= w_dvd_next;
            r_rem  <= w_rem_next;
            r_cnt  <= r_cnt + 6'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_dbz_out <= 1'b0;
        end else if (w_finish) begin
`ifdef DIVU_SEQ_ZERO_FAST_EN
            if (r_zero) begin
                r_quo_out <= '1;
                r_rem_out <= r_dvd;
            end else begin
                r_quo_out <= w_dvd_next;
                r_rem_out <= w_rem_next;
            end
`else
            r_quo_out <= w_dvd_next;
            r_rem_out <= w_rem_next;
`endif
            r_dbz_out <= r_zero;
        end
    end

    assign o_ready       = (r_state == S_IDLE);
    assign o_valid       = (r_state == S_DONE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_quotient    = r_quo_out;
    assign o_remainder   = r_rem_out;
    assign o_div_by_zero = r_dbz_out;

endmodule

// File: doc/divu_seq_ctrl.md
DIVU_SEQ_CTRL -- requirements
Module: divu_seq_ctrl

Interface
REQ-001 Parameter: STEPS_PER_CYCLE, default 1, restoring-division iterations per clock; legal values 1, 2, 4.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request valid.
REQ-005 o_ready  output  1  block accepts a request this cycle.
REQ-006 i_dividend  input  32  unsigned dividend, sampled on accept only.
REQ-007 i_divisor  input  32  unsigned divisor, sampled on accept only.
REQ-008 o_valid  output  1  result valid.
REQ-009 i_ready  input  1  consumer accepts result.
REQ-010 o_quotient  output  32  unsigned quotient.
REQ-011 o_remainder  output  32  unsigned remainder.
REQ-012 o_div_by_zero  output  1  captured divisor was zero; qualified by o_valid.
REQ-013 o_busy  output  1  high in BUSY and DONE states.

Function
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 o_ready = 1 only in IDLE; o_valid = 1 only in DONE; both driven directly from state.
REQ-016 Accept = i_valid & o_ready at a rising edge: latch dividend and divisor, clear partial remainder (33-bit) and step counter, move to BUSY.
REQ-017 Each BUSY cycle performs STEPS_PER_CYCLE iterations: rem = {rem[31:0], dividend MSB}; dividend shifts left by one; if rem >= {1'b0, divisor} then rem -= divisor and quotient bit = 1, else 0; quotient bits fill MSB first.
REQ-018 Compare and subtract use 33-bit width; no truncation before the compare.
REQ-019 After 32/STEPS_PER_CYCLE BUSY cycles, move to DONE; o_valid rises exactly 32/STEPS_PER_CYCLE cycles after the accept edge.
REQ-020 Result is identical to combinational 32-stage restoring division: quotient = floor(dividend/divisor), remainder = dividend mod divisor, for divisor != 0.
REQ-021 Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend, o_div_by_zero = 1.
REQ-022 DONE: o_quotient, o_remainder, o_div_by_zero held stable until i_ready = 1; on that edge move to IDLE.
REQ-023 No accept in the DONE->IDLE cycle; minimum request spacing is latency + 2 cycles.
REQ-024 i_valid, i_dividend, i_divisor ignored outside IDLE; changes during BUSY do not affect the result.
REQ-025 Result registers retain the last result in IDLE until the next DONE overwrites them.
REQ-026 i_ready ignored outside DONE.

Reset
REQ-027 i_rst_n low asynchronously forces state IDLE, counter 0, all datapath registers 0, o_quotient = 0, o_remainder = 0, o_div_by_zero = 0, o_valid = 0, o_busy = 0, o_ready = 1.
REQ-028 Reset asserted during BUSY or DONE aborts the operation; no o_valid pulse follows deassertion.
REQ-029 The first accept may occur at the first rising edge after i_rst_n deasserts.

Configuration
REQ-030 Macro DIVU_SEQ_ZERO_FAST_EN defined: divisor == 0 at accept moves directly to DONE with the REQ-021 result; o_valid rises 1 cycle after accept.
REQ-031 Macro DIVU_SEQ_ZERO_FAST_EN undefined: divisor == 0 runs the full iteration sequence; latency per REQ-019; results and flag are identical to REQ-021.

Verification
REQ-032 STEPS_PER_CYCLE=1: accept 100/7 -> o_valid exactly 32 cycles later, quotient 14, remainder 2, flag 0.
REQ-033 Accept 0xFFFFFFFF/1 and then 3/10 -> results 0xFFFFFFFF r0, then 0 r3; for STEPS_PER_CYCLE=4, latency is 8 cycles.
REQ-034 Accept 5/0 -> quotient 0xFFFFFFFF, remainder 5, flag 1; latency 1 with DIVU_SEQ_ZERO_FAST_EN, 32 without.
REQ-035 Hold i_ready low 5 cycles in DONE and toggle i_valid/inputs -> outputs stable, o_ready 0; i_ready high -> IDLE next cycle.
REQ-036 Accept 1000/3, assert i_rst_n low at BUSY cycle 10 -> all outputs at reset values immediately; no o_valid after release; a new 9/2 request returns 4 r1.
REQ-037 Random regression of 10k pairs including 0, 1, 0xFFFFFFFF, and divisor > dividend -> results match the arithmetic model.
